// File: rtl/csa_accum_ctrl_if.sv
// Operand stream, result stream and abort for csa_accum_ctrl.
// The slave side is the controller; the master side is the producer and consumer.
interface csa_accum_ctrl_if #(
    parameter int IN_W  = 14,
    parameter int ACC_W = 20
);
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [7:0]       out_count;

    modport master (
        output clear, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count
    );

    modport slave (
        input  clear, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count
    );
endinterface

// File: rtl/csa_accum_ctrl.sv
// Multi-operand accumulator: one 3:2 carry-save fold per accepted beat,
// a single carry-propagate add at packet end, result held until taken.
//
// state   | meaning
// IDLE    | waiting for the first beat of a packet
// ACCUM   | folding beats into sum/carry until in_last
// RESOLVE | adding sum and carry into the result register
// DONE    | result presented, waiting for out_ready
module csa_accum_ctrl #(
    parameter int IN_W  = 14,
    parameter int ACC_W = 20
) (
    input  logic clk,
    input  logic rst,
    csa_accum_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

    state_t           state_q;
    logic [ACC_W-1:0] sum_q;
    logic [ACC_W-1:0] carry_q;
    logic [ACC_W-1:0] res_q;
    logic [7:0]       cnt_q;
    logic [7:0]       count_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [ACC_W-1:0] data_ext;
    logic [ACC_W-1:0] maj;
    logic [ACC_W-1:0] csa_sum_d;
    logic [ACC_W-1:0] csa_carry_d;
    logic [7:0]       cnt_inc_d;

    assign data_ext    = {{(ACC_W-IN_W){1'b0}}, bus.in_data};
    assign maj         = (sum_q & carry_q) | (sum_q & data_ext) | (carry_q & data_ext);
    assign csa_sum_d   = sum_q ^ carry_q ^ data_ext;
    assign csa_carry_d = maj << 1;
    assign cnt_inc_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = res_q;
    assign bus.out_count = count_q;

    // in_ready/out_valid are registered alongside the state so they never
    // depend combinationally on in_valid or out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sum_q       <= '0;
            carry_q     <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (bus.clear) begin
            state_q     <= IDLE;
            sum_q       <= '0;
            carry_q     <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        sum_q      <= data_ext;
                        carry_q    <= '0;
                        cnt_q      <= 8'd1;
                        state_q    <= bus.in_last ? RESOLVE : ACCUM;
                        in_ready_q <= ~bus.in_last;
                    end
                end
                ACCUM: begin
                    if (bus.in_valid) begin
                        sum_q   <= csa_sum_d;
                        carry_q <= csa_carry_d;
                        cnt_q   <= cnt_inc_d;
                        if (bus.in_last) begin
                            state_q    <= RESOLVE;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    res_q       <= sum_q + carry_q;
                    count_q     <= cnt_q;
                    state_q     <= DONE;
                    out_valid_q <= 1'b1;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
